ltsm_ctrl_param: RTL



---
 rtl/ltsm_pkg.sv | 73 +++++++
 rtl/ltsm_timer.sv | 27 ++
 rtl/ltsm_ctrl_param.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ltsm_pkg.sv
// ltsm_pkg: shared types and helpers for the parametrised link-training
// state machine controller.
//   lt_state_t   - 3-bit training state, encodings exposed on state_o
//   sb_mux_sel_t - sideband pin-mux select
//   mb_mux_sel_t - mainband pin-mux select
//   mux_sel_t    - bundle of the four mux selects driven by the controller
//   PH_*         - bit index of each training phase in the start/done/err vectors
package ltsm_pkg;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_SBINIT     = 3'd1,
        ST_MBINIT     = 3'd2,
        ST_MBTRAIN    = 3'd3,
        ST_LINKINIT   = 3'd4,
        ST_ACTIVE     = 3'd5,
        ST_TRAINERROR = 3'd6
    } lt_state_t;

    typedef enum logic [1:0] {
        SB_Z        = 2'd0,
        SB_DISABLED = 2'd1,
        SB_INIT     = 2'd2,
        SB_COMS     = 2'd3
    } sb_mux_sel_t;

    typedef enum logic [1:0] {
        MB_Z        = 2'd0,
        MB_DISABLED = 2'd1,
        MB_INIT     = 2'd2,
        MB_COMS     = 2'd3
    } mb_mux_sel_t;

    typedef struct packed {
        sb_mux_sel_t sb_tx;
        sb_mux_sel_t sb_rx;
        mb_mux_sel_t mb_tx;
        mb_mux_sel_t mb_rx;
    } mux_sel_t;

    localparam int NUM_PHASES  = 4;
    localparam int PH_SBINIT   = 0;
    localparam int PH_MBINIT   = 1;
    localparam int PH_MBTRAIN  = 2;
    localparam int PH_LINKINIT = 3;

    // True for the four states that run a training sub-block.
    function automatic logic is_phase(input lt_state_t s);
        return s inside {ST_SBINIT, ST_MBINIT, ST_MBTRAIN, ST_LINKINIT};
    endfunction

    // Bit position of a phase state in the start/done/err vectors.
    function automatic logic [1:0] phase_idx(input lt_state_t s);
        case (s)
            ST_MBINIT:   return 2'(PH_MBINIT);
            ST_MBTRAIN:  return 2'(PH_MBTRAIN);
            ST_LINKINIT: return 2'(PH_LINKINIT);
            default:     return 2'(PH_SBINIT);
        endcase
    endfunction

    // Pin-mux routing owned by each state.
    function automatic mux_sel_t mux_sel_for(input lt_state_t s);
        case (s)
            ST_SBINIT:                  return '{SB_INIT, SB_INIT, MB_Z, MB_INIT};
            ST_MBINIT, ST_MBTRAIN:      return '{SB_COMS, SB_COMS, MB_INIT, MB_INIT};
            ST_LINKINIT, ST_ACTIVE:     return '{SB_COMS, SB_COMS, MB_COMS, MB_COMS};
            ST_TRAINERROR:              return '{SB_COMS, SB_COMS, MB_DISABLED, MB_DISABLED};
            default:                    return '{SB_DISABLED, SB_INIT, MB_Z, MB_INIT};
        endcase
    endfunction

endpackage

// File: rtl/ltsm_timer.sv
// ltsm_timer: clearable, saturating up-counter measuring time spent in the
// current training state.
//   clk_100MHz - clock
//   reset_n    - synchronous active-low reset (count -> 0)
//   clear      - synchronous clear, count restarts at 0
//   count      - cycles since the last clear, sticks at all-ones
module ltsm_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    // NOTE: reset is sampled on the clock edge (synchronous), and all state
    // is updated with non-blocking assignments so every flop sees the
    // pre-edge values of its neighbours.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ltsm_ctrl_param.sv
// ltsm_ctrl_param: link-training state machine controller.
// Sequences RESET -> SBINIT -> MBINIT -> MBTRAIN -> LINKINIT -> ACTIVE with a
// start/done/err handshake per phase, supervises each phase with a timeout,
// and retries through TRAINERROR up to MAX_RETRIES times before locking out.
//   clk_100MHz, reset_n          - clock, synchronous active-low reset
//   enable_i                     - low forces RESET and clears retries/lockout
//   start_LT_i                   - training request
//   phase_done_i / phase_err_i   - per-phase handshake, bit0=SBINIT..bit3=LINKINIT
//   remote_err_i                 - TRAINERROR message from the link partner
//   linkdown_i                   - link failure while ACTIVE
//   lane_mask_i                  - usable MB lanes, captured on MBINIT entry
//   phase_start_o                - one-cycle start pulse for the entered phase
//   sb_*_sel_o / mb_*_sel_o      - pin-mux selects
//   mb_lane_en_o                 - active MB lane mask
//   state_o, link_up_o, trainerror_o, lockout_o, retry_cnt_o - status
module ltsm_ctrl_param
    import ltsm_pkg::*;
#(
    parameter int NUM_MB_LANES     = 16,
    parameter int TIMEOUT_CYCLES   = 800000,
    parameter int RESET_MIN_CYCLES = 400,
    parameter int TRAINERROR_HOLD  = 100,
    parameter int MAX_RETRIES      = 3
) (
    input  logic                    clk_100MHz,
    input  logic                    reset_n,
    input  logic                    enable_i,
    input  logic                    start_LT_i,
    input  logic [3:0]              phase_done_i,
    input  logic [3:0]              phase_err_i,
    input  logic                    remote_err_i,
    input  logic                    linkdown_i,
    input  logic [NUM_MB_LANES-1:0] lane_mask_i,
    output logic [3:0]              phase_start_o,
    output logic [1:0]              sb_tx_sel_o,
    output logic [1:0]              sb_rx_sel_o,
    output logic [1:0]              mb_tx_sel_o,
    output logic [1:0]              mb_rx_sel_o,
    output logic [NUM_MB_LANES-1:0] mb_lane_en_o,
    output logic [2:0]              state_o,
    output logic                    link_up_o,
    output logic                    trainerror_o,
    output logic                    lockout_o,
    output logic [1:0]              retry_cnt_o
);

    localparam int MAX_AB    = (TIMEOUT_CYCLES > RESET_MIN_CYCLES) ? TIMEOUT_CYCLES : RESET_MIN_CYCLES;
    localparam int TIMER_MAX = (MAX_AB > TRAINERROR_HOLD) ? MAX_AB : TRAINERROR_HOLD;
    localparam int TW        = $clog2(TIMER_MAX) + 1;

    localparam logic [TW-1:0] RESET_LAST   = TW'(RESET_MIN_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST    = TW'(TRAINERROR_HOLD - 1);
    localparam logic [1:0]    MAX_R        = 2'(MAX_RETRIES);

    lt_state_t     state;
    lt_state_t     state_nxt;
    mux_sel_t      sel;
    logic [TW-1:0] timer;
    logic          first_cycle;
    logic          mask_zero;
    logic [1:0]    idx;
    logic          hold_done;

    // The timer restarts on every state change, so timer==0 marks the first
    // cycle in a state.
    ltsm_timer #(.WIDTH(TW)) u_timer (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .clear      (state_nxt != state),
        .count      (timer)
    );

    assign first_cycle = (timer == '0);
    assign idx         = phase_idx(state);
    assign mask_zero   = (state == ST_MBINIT) && (mb_lane_en_o == '0);
    assign hold_done   = (state == ST_TRAINERROR) && (timer == HOLD_LAST);

    // NOTE: every signal assigned in always_comb gets a default at the top so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (!enable_i) begin
            state_nxt = ST_RESET;
        end else begin
            case (state)
                ST_RESET: begin
                    if (timer >= RESET_LAST && start_LT_i) state_nxt = ST_SBINIT;
                end
                ST_SBINIT, ST_MBINIT, ST_MBTRAIN, ST_LINKINIT: begin
                    // Handshake inputs are ignored while the start pulse is out.
                    if (!first_cycle) begin
                        if (phase_err_i[idx] || remote_err_i || mask_zero)
                            state_nxt = ST_TRAINERROR;
                        else if (phase_done_i[idx])
                            state_nxt = lt_state_t'(state + 3'd1);
                        else if (timer == TIMEOUT_LAST)
                            state_nxt = ST_TRAINERROR;
                    end
                end
                ST_ACTIVE: begin
                    if (linkdown_i || remote_err_i) state_nxt = ST_TRAINERROR;
                end
                ST_TRAINERROR: begin
                    // Once locked out, the saturated timer never matches again.
                    if (hold_done && retry_cnt_o < MAX_R) state_nxt = ST_RESET;
                end
                default: state_nxt = ST_RESET;
            endcase
        end
    end

    // Outputs are decoded from state_nxt so they change on the same edge as
    // state_o.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state         <= ST_RESET;
            sel           <= '{SB_DISABLED, SB_INIT, MB_Z, MB_INIT};
            phase_start_o <= '0;
            mb_lane_en_o  <= '0;
            link_up_o     <= 1'b0;
            trainerror_o  <= 1'b0;
            lockout_o     <= 1'b0;
            retry_cnt_o   <= '0;
        end else begin
            state         <= state_nxt;
            sel           <= mux_sel_for(state_nxt);
            link_up_o     <= (state_nxt == ST_ACTIVE);
            trainerror_o  <= (state_nxt == ST_TRAINERROR);
            phase_start_o <= (state_nxt != state && is_phase(state_nxt))
                             ? (4'b0001 << phase_idx(state_nxt)) : 4'b0000;

            // Lane mask is captured once on MBINIT entry and held through ACTIVE.
            if (state_nxt == ST_MBINIT && state != ST_MBINIT)
                mb_lane_en_o <= lane_mask_i;
            else if (state_nxt inside {ST_RESET, ST_SBINIT, ST_TRAINERROR})
                mb_lane_en_o <= '0;

            // Disable wins over the retry increment on a TRAINERROR -> RESET move.
            if (!enable_i)
                retry_cnt_o <= '0;
            else if (state_nxt == ST_ACTIVE)
                retry_cnt_o <= '0;
            else if (state == ST_TRAINERROR && state_nxt == ST_RESET)
                retry_cnt_o <= retry_cnt_o + 2'd1;

            if (!enable_i)
                lockout_o <= 1'b0;
            else if (hold_done && retry_cnt_o >= MAX_R)
                lockout_o <= 1'b1;
        end
    end

    assign state_o     = state;
    assign sb_tx_sel_o = sel.sb_tx;
    assign sb_rx_sel_o = sel.sb_rx;
    assign mb_tx_sel_o = sel.mb_tx;
    assign mb_rx_sel_o = sel.mb_rx;

endmodule
